// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/forwarding unit: forward-select codes,
// RV32 opcodes and the flag portion of a shadow-pipeline entry.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // The rd field width is a module parameter, so the full entry type wraps
  // these flags together with rd inside the module.
  typedef struct packed {
    logic valid;
    logic we;
    logic load;
  } shadowFlags_t;

endpackage

// File: rtl/src_use_decode.sv
// Decodes which register source operands an RV32 instruction actually reads,
// so unused rs fields (immediates in disguise) never raise false hazards.
module src_use_decode
  import hazard_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       useRs1,
  output logic       useRs2
);

  always_comb begin
    useRs1 = !(opcode inside {OP_LUI, OP_AUIPC, OP_JAL});
    useRs2 = opcode inside {OP_REG, OP_STORE, OP_BRANCH};
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding unit beside ID/EX: tracks in-flight destinations in a
// private shadow pipeline and produces forward selects, load-use stall and flush.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter bit FWD_EN       = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_instr,
  input  logic        id_valid,
  input  logic        id_rd_we,
  input  logic        id_is_load,
  input  logic        branch_taken,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        stall,
  output logic        flush,
  output logic        ex_bubble
);

  localparam int               CNT_W    = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  typedef struct packed {
    shadowFlags_t      f;
    logic [REG_AW-1:0] rd;
  } shadowEntry_t;

  shadowEntry_t      exEnt, memEnt, wbEnt, exNext;
  logic [CNT_W-1:0]  flushCnt;
  logic              useRs1, useRs2;
  logic [REG_AW-1:0] rs1, rs2, rd;
  logic              hitExA, hitExB, hitMemA, hitMemB;
  logic              loadUse, rawStall, bubbleIn;
  logic [1:0]        fwdANext, fwdBNext;
  logic              unusedBits;

  assign rs1 = id_instr[15 +: REG_AW];
  assign rs2 = id_instr[20 +: REG_AW];
  assign rd  = id_instr[7 +: REG_AW];

  // The register file is write-first, so the WB occupant never needs action;
  // it and the non-register instruction fields are intentionally unread.
  assign unusedBits = ^{id_instr, wbEnt};

  src_use_decode uDecode (
    .opcode (id_instr[6:0]),
    .useRs1 (useRs1),
    .useRs2 (useRs2)
  );

  function automatic logic hits(logic used, logic [REG_AW-1:0] rs, shadowEntry_t e);
    return used && (rs != '0) && e.f.valid && e.f.we && (e.rd == rs);
  endfunction

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    hitExA   = hits(useRs1, rs1, exEnt);
    hitExB   = hits(useRs2, rs2, exEnt);
    hitMemA  = hits(useRs1, rs1, memEnt);
    hitMemB  = hits(useRs2, rs2, memEnt);
    loadUse  = exEnt.f.load && (hitExA || hitExB);
    rawStall = FWD_EN ? loadUse : (hitExA || hitExB || hitMemA || hitMemB);
  end

  // A taken branch kills the wrong-path consumer, so flush overrides stall.
  assign flush    = branch_taken || (flushCnt != '0);
  assign stall    = id_valid && rawStall && !flush;
  assign bubbleIn = stall || flush || !id_valid;

  always_comb begin
    fwdANext = FWD_RF;
    fwdBNext = FWD_RF;
    exNext   = '0;
    if (!bubbleIn) begin
      exNext.f.valid = 1'b1;
      exNext.f.we    = id_rd_we;
      exNext.f.load  = id_is_load;
      exNext.rd      = rd;
      if (FWD_EN) begin
        // The younger producer (now in EX, next in MEM) wins over the older one.
        if (hitExA)       fwdANext = FWD_MEM;
        else if (hitMemA) fwdANext = FWD_WB;
        if (hitExB)       fwdBNext = FWD_MEM;
        else if (hitMemB) fwdBNext = FWD_WB;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample pre-edge values and the shadow pipeline shifts as one.
  always_ff @(posedge clk) begin
    if (rst) begin
      exEnt     <= '0;
      memEnt    <= '0;
      wbEnt     <= '0;
      flushCnt  <= '0;
      fwd_a     <= FWD_RF;
      fwd_b     <= FWD_RF;
      ex_bubble <= 1'b1;
    end else begin
      wbEnt     <= memEnt;
      memEnt    <= exEnt;
      exEnt     <= exNext;
      fwd_a     <= fwdANext;
      fwd_b     <= fwdBNext;
      ex_bubble <= bubbleIn;
      if (branch_taken)         flushCnt <= CNT_LOAD;
      else if (flushCnt != '0)  flushCnt <= flushCnt - CNT_W'(1);
    end
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard and forwarding unit for the five-stage RISC-V core, placed beside the ID/EX pipeline register. It tracks destination registers in flight through EX, MEM and WB in its own shadow pipeline, so the datapath does not have to feed back destination fields. It generates registered per-operand forward selects for the EX stage, a load-use stall, and a multi-cycle flush after a taken branch. Unlike a purely combinational comparator, it decodes which source operands are actually used, never forwards x0, and has a stall-only mode for builds without bypass muxes.

## Interface
- REG_AW, 5: register-index width; register file holds 2^REG_AW entries.
- FLUSH_CYCLES, 2: cycles `flush` stays high per taken branch; legal range ≥1.
- FWD_EN, 1: 1 = forward from MEM/WB. 0 = stall on every RAW hazard; `fwd_a`/`fwd_b` are held at 00.

- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- id_instr  in  32  instruction currently in ID.
- id_valid  in  1  ID holds a real instruction.
- id_rd_we  in  1  ID instruction writes rd.
- id_is_load  in  1  ID instruction is a load.
- branch_taken  in  1  EX resolved a taken branch or jump this cycle.
- fwd_a  out  2  EX rs1 source: 00 regfile, 01 MEM result, 10 WB result.
- fwd_b  out  2  EX rs2 source, same encoding.
- stall  out  1  hold PC and IF/ID, insert a bubble into EX.
- flush  out  1  kill IF/ID contents.
- ex_bubble  out  1  EX holds a bubble (registered).

## Operation
- Shadow entries EX, MEM and WB each hold {valid, we, load, rd}.
- The shadow pipeline advances every cycle: WB←MEM, MEM←EX.
- EX takes the ID info, or a bubble (all zero) when `stall`, `flush` or `!id_valid` is high.
- Source use is decoded from `id_instr[6:0]`:
  - rs1 is unused for LUI, AUIPC and JAL.
  - rs2 is used only for R-type, STORE and BRANCH.
- Hit: a used source with rs≠0 matching an entry that has valid & we.
- Forward select, computed in ID and registered into `fwd_a`/`fwd_b`:
  - Hit on shadow EX → 01. The producer is in MEM when the consumer reaches EX.
  - Else hit on shadow MEM → 10.
  - Else 00.
  - MEM has priority when both hit.
- The register file is write-first, so a match on the shadow WB entry needs no action.
- Load-use: shadow EX has load & we & rd≠0 and is hit → `stall`=1.
  - The bubble moves the load to MEM.
  - Next cycle the consumer re-evaluates and gets 10.
- FWD_EN=0: any hit on shadow EX or MEM → `stall`.
- Flush:
  - `flush` = `branch_taken` | (cnt≠0).
  - `branch_taken` loads cnt with FLUSH_CYCLES−1, which reloads even when a flush is already active.
  - Otherwise cnt decrements to 0.
  - The shadow EX entry becomes a bubble.
- `branch_taken` together with a load-use condition: flush wins and `stall`=0.

## Timing
- Reset values: `fwd_a`=`fwd_b`=00, `stall`=0, `flush`=0, `ex_bubble`=1, cnt=0, all shadow entries invalid.
- Reset asserted mid-flush or mid-stall clears everything on the next edge.
- `stall` and `flush` are combinational from current inputs and state, valid in the same cycle.
- `fwd_*` and `ex_bubble` have 1-cycle latency: valid in the cycle the instruction occupies EX.
- A load-use stall lasts exactly 1 cycle (FWD_EN=1).
- Stall-only mode (FWD_EN=0) lasts up to 2 cycles.
- While `id_valid`=0, no stall is raised.

## Structure
- Shared package `hazard_pkg`:
  - fwd-select localparams FWD_RF/FWD_MEM/FWD_WB.
  - RV32 opcode constants.
  - Shadow-entry struct type, parametrised by REG_AW through the module.
- One sub-module, `src_use_decode`: opcode → {use_rs1, use_rs2}.
- Everything else is flat.

## Test plan
- ADD x5,x1,x2 then SUB x6,x5,x3 → in SUB's EX cycle `fwd_a`=01, `stall`=0.
- ADD x5 then NOP then OR x7,x4,x5 → `fwd_b`=10.
- ADD x5 followed directly by ADD x6,x5,x5 → both selects 01 (MEM priority confirmed with an older x5 write in MEM).
- LW x5 then ADD x6,x5,x1 → `stall`=1 for one cycle, `ex_bubble`=1, then `fwd_a`=10.
- LW x0 then ADD x6,x0,x1 → no stall, `fwd_a`=00.
- LUI x5 then LUI x6 (rs1 field coincidentally =5) → no hazard.
- `branch_taken` with FLUSH_CYCLES=3 and a simultaneous load-use → `flush` high 3 cycles, `stall`=0.
- A second `branch_taken` in cycle 2 extends `flush` to cycle 4.
- FWD_EN=0, ADD x5 then ADD x6,x5,x1 → `stall` 2 cycles, `fwd_a`=00.
- `rst` pulsed during the flush → all outputs at reset values next cycle.
